// File: rtl/seg_pkg.sv
// Shared 7-segment constants and scan-FSM types for the display driver and the bus decoder.
// Patterns are active-low, bit6..0 = g..a.
package seg_pkg;

  localparam logic [6:0] ZERO  = 7'b1000000;
  localparam logic [6:0] ONE   = 7'b1111001;
  localparam logic [6:0] TWO   = 7'b0100100;
  localparam logic [6:0] THREE = 7'b0110000;
  localparam logic [6:0] FOUR  = 7'b0011001;
  localparam logic [6:0] FIVE  = 7'b0010010;
  localparam logic [6:0] SIX   = 7'b0000010;
  localparam logic [6:0] SEVEN = 7'b1111000;
  localparam logic [6:0] EIGHT = 7'b0000000;
  localparam logic [6:0] NINE  = 7'b0010000;
  localparam logic [6:0] OFF   = 7'b1111111;

  localparam logic [3:0] BCD_BLANK   = 4'hA;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {StIdle, StSettle, StHold, StBad} scan_state_e;

  function automatic logic anode_is_single(input logic [3:0] an);
    return $countones(~an) == 1;
  endfunction

  // Position of the low anode; only meaningful when exactly one anode is low.
  function automatic logic [1:0] anode_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to BCD lookup; blank decodes to BCD_BLANK,
// anything unrecognised to BCD_INVALID with o_err set.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_err
);

  always_comb begin
    o_code = BCD_INVALID;
    o_err  = 1'b0;
    case (i_seg)
      ZERO:    o_code = 4'd0;
      ONE:     o_code = 4'd1;
      TWO:     o_code = 4'd2;
      THREE:   o_code = 4'd3;
      FOUR:    o_code = 4'd4;
      FIVE:    o_code = 4'd5;
      SIX:     o_code = 4'd6;
      SEVEN:   o_code = 4'd7;
      EIGHT:   o_code = 4'd8;
      NINE:    o_code = 4'd9;
      OFF:     o_code = BCD_BLANK;
      default: o_err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a 4-digit multiplexed 7-segment bus and publishes coherent frames of the
// four displayed BCD digits, with anode-fault and stale-display reporting.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [3:0] digit,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       anode_err,
  output logic       stale
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntTarget = CntW'(STABLE_CYCLES);
  localparam logic [ToW-1:0]  ToLimit   = ToW'(TIMEOUT_CYCLES);

  logic [6:0]      r_seg_s1, r_seg_s2;
  logic [3:0]      r_dig_s1, r_dig_s2;
  scan_state_e     r_state;
  logic [CntW-1:0] r_cnt;
  logic [3:0]      r_anode;
  logic [6:0]      r_pat;
  logic            r_anode_err;
  logic [3:0]      r_shadow [4];
  logic [3:0]      r_mask, r_err;
  logic [3:0]      r_ones, r_tens, r_hundreds, r_thousands;
  logic            r_frame_valid, r_frame_err, r_stale;
  logic [ToW-1:0]  r_to_cnt;

  logic       w_idle, w_single, w_multi, w_same, w_capture, w_fire, w_err;
  logic [1:0] w_idx;
  logic [3:0] w_cap_bit, w_code;

  // Sync flops reset to the idle bus so reset release never looks like an anode fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= OFF;
      r_seg_s2 <= OFF;
      r_dig_s1 <= 4'hF;
      r_dig_s2 <= 4'hF;
    end else begin
      r_seg_s1 <= seg;
      r_seg_s2 <= r_seg_s1;
      r_dig_s1 <= digit;
      r_dig_s2 <= r_dig_s1;
    end
  end

  seg_pattern_decode u_decode (
    .i_seg  (r_seg_s2),
    .o_code (w_code),
    .o_err  (w_err)
  );

  always_comb begin
    w_idle    = (r_dig_s2 == 4'hF);
    w_single  = anode_is_single(r_dig_s2);
    w_multi   = !w_idle && !w_single;
    w_same    = (r_dig_s2 == r_anode) && (r_seg_s2 == r_pat);
    w_idx     = anode_index(r_dig_s2);
    w_capture = (r_state == StSettle) && w_same && ((r_cnt + 1'b1) == CntTarget);
    w_cap_bit = w_capture ? (4'b0001 << w_idx) : 4'b0000;
    w_fire    = (r_mask == 4'hF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_anode     <= 4'hF;
      r_pat       <= OFF;
      r_anode_err <= 1'b0;
    end else begin
      r_anode_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_single) begin
            r_state <= StSettle;
            r_cnt   <= CntW'(1);
            r_anode <= r_dig_s2;
            r_pat   <= r_seg_s2;
          end else if (w_multi) begin
            r_state     <= StBad;
            r_anode_err <= 1'b1;
          end
        end
        StSettle, StHold: begin
          if (w_idle) begin
            r_state <= StIdle;
          end else if (w_multi) begin
            r_state     <= StBad;
            r_anode_err <= 1'b1;
          end else if (r_state == StSettle && w_same) begin
            if (w_capture) r_state <= StHold;
            else r_cnt <= r_cnt + 1'b1;
          end else if (r_state == StSettle || r_dig_s2 != r_anode) begin
            // New anode, or a pattern change while still settling: restart the run.
            r_state <= StSettle;
            r_cnt   <= CntW'(1);
            r_anode <= r_dig_s2;
            r_pat   <= r_seg_s2;
          end
        end
        StBad: begin
          if (w_idle) begin
            r_state <= StIdle;
          end else if (w_single) begin
            r_state <= StSettle;
            r_cnt   <= CntW'(1);
            r_anode <= r_dig_s2;
            r_pat   <= r_seg_s2;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // A capture in the frame-publish cycle survives the clear and seeds the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_shadow[i] <= 4'h0;
      r_mask <= 4'h0;
      r_err  <= 4'h0;
    end else begin
      r_mask <= (w_fire ? 4'h0 : r_mask) | w_cap_bit;
      r_err  <= ((w_fire ? 4'h0 : r_err) & ~w_cap_bit) | (w_err ? w_cap_bit : 4'h0);
      if (w_capture) r_shadow[w_idx] <= w_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones        <= 4'h0;
      r_tens        <= 4'h0;
      r_hundreds    <= 4'h0;
      r_thousands   <= 4'h0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_to_cnt      <= '0;
      r_stale       <= 1'b0;
    end else begin
      r_frame_valid <= w_fire;
      if (w_fire) begin
        r_ones      <= r_shadow[0];
        r_tens      <= r_shadow[1];
        r_hundreds  <= r_shadow[2];
        r_thousands <= r_shadow[3];
        r_frame_err <= |r_err;
        r_to_cnt    <= '0;
        r_stale     <= 1'b0;
      end else if (r_to_cnt != ToLimit) begin
        r_to_cnt <= r_to_cnt + 1'b1;
        if ((r_to_cnt + 1'b1) == ToLimit) r_stale <= 1'b1;
      end
    end
  end

  assign ones        = r_ones;
  assign tens        = r_tens;
  assign hundreds    = r_hundreds;
  assign thousands   = r_thousands;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign anode_err   = r_anode_err;
  assign stale       = r_stale;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed frame table, multi-cycle corner cases
// and a randomized bus checked every cycle against a run-length reference model.
module tb_seg_scan_decoder;

  localparam int unsigned Stable  = 4;
  localparam int unsigned Timeout = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] seg = 7'h7F;
  logic [3:0] digit = 4'hF;
  logic [3:0] ones, tens, hundreds, thousands;
  logic       frame_valid, frame_err, anode_err, stale;

  seg_scan_decoder #(
    .STABLE_CYCLES  (Stable),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .digit       (digit),
    .ones        (ones),
    .tens        (tens),
    .hundreds    (hundreds),
    .thousands   (thousands),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .anode_err   (anode_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fv_cnt, ae_cnt;
  logic [15:0] last_digits;
  logic        last_fe;
  logic [6:0]  pat_tab [10];

  // Reference model state: sync delay line, run tracking and frame bookkeeping.
  logic [6:0] m_p1_seg, m_p2_seg, m_prev_p;
  logic [3:0] m_p1_dig, m_p2_dig, m_prev_a;
  int         m_run, m_prev_cls, m_cyc, m_last_frame;
  bit         m_armed, m_fv, m_fe, m_ae, m_stale;
  logic [3:0] m_shadow [4];
  logic [3:0] m_out [4];
  logic [3:0] m_mask, m_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (p == pat_tab[i]) return {1'b0, 4'(i)};
    if (p == 7'h7F) return {1'b0, 4'hA};
    return {1'b1, 4'hF};
  endfunction

  task automatic model_reset();
    m_p1_seg = 7'h7F; m_p2_seg = 7'h7F; m_prev_p = 7'h7F;
    m_p1_dig = 4'hF;  m_p2_dig = 4'hF;  m_prev_a = 4'hF;
    m_run = 0; m_prev_cls = 0; m_cyc = 0; m_last_frame = 0;
    m_armed = 0; m_fv = 0; m_fe = 0; m_ae = 0; m_stale = 0;
    m_mask = 4'h0; m_err = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 4'h0;
      m_out[i] = 4'h0;
    end
  endtask

  // One clock edge: consumes the bus sample seen two edges ago.
  task automatic model_step();
    logic [3:0] a;
    logic [6:0] p;
    logic [4:0] dec;
    int cls, idx;
    a = m_p2_dig; p = m_p2_seg;
    m_p2_dig = m_p1_dig; m_p2_seg = m_p1_seg;
    m_p1_dig = digit;    m_p1_seg = seg;
    m_cyc++;
    cls = (a == 4'hF) ? 0 : (($countones(~a) == 1) ? 1 : 2);
    m_fv = (m_mask == 4'hF);
    if (m_fv) begin
      for (int i = 0; i < 4; i++) m_out[i] = m_shadow[i];
      m_fe = |m_err;
      m_mask = 4'h0;
      m_err = 4'h0;
      m_last_frame = m_cyc;
    end
    m_ae = (cls == 2) && (m_prev_cls != 2);
    if (a != m_prev_a) begin
      m_armed = 1;
      m_run = 1;
    end else if (p == m_prev_p) begin
      m_run++;
    end else begin
      m_run = 1;
    end
    // At most one capture per anode dwell: the first run of Stable identical samples.
    if (cls == 1 && m_armed && m_run == Stable) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
      dec = ref_decode(p);
      m_shadow[idx] = dec[3:0];
      m_mask[idx] = 1'b1;
      m_err[idx] = dec[4];
      m_armed = 0;
    end
    m_prev_a = a; m_prev_p = p; m_prev_cls = cls;
    m_stale = (m_cyc - m_last_frame) >= Timeout;
  endtask

  task automatic cyc(input logic [6:0] s, input logic [3:0] d);
    seg = s;
    digit = d;
    @(posedge clk);
    model_step();
    #1;
    check("cycle", {ones, tens, hundreds, thousands, frame_valid, m_fv ? frame_err : 1'b0,
                    anode_err, stale},
          {m_out[0], m_out[1], m_out[2], m_out[3], m_fv, m_fv ? m_fe : 1'b0, m_ae, m_stale});
    if (frame_valid) begin
      fv_cnt++;
      last_digits = {thousands, hundreds, tens, ones};
      last_fe = frame_err;
    end
    if (anode_err) ae_cnt++;
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) cyc(s, d);
  endtask

  task automatic scan(input logic [27:0] pats, input int dwell);
    for (int i = 0; i < 4; i++) hold(pats[7*i +: 7], ~(4'b0001 << i), dwell);
  endtask

  task automatic apply_reset();
    seg = 7'h7F;
    digit = 4'hF;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {ones, tens, hundreds, thousands, frame_valid, frame_err,
                            anode_err, stale}, 20'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [27:0] pats;       // {thousands, hundreds, tens, ones}
    logic [15:0] exp_digits; // {thousands, hundreds, tens, ones}
    logic        exp_fe;
  } vec_t;

  vec_t vecs [4];

  initial begin
    pat_tab[0] = 7'b1000000; pat_tab[1] = 7'b1111001; pat_tab[2] = 7'b0100100;
    pat_tab[3] = 7'b0110000; pat_tab[4] = 7'b0011001; pat_tab[5] = 7'b0010010;
    pat_tab[6] = 7'b0000010; pat_tab[7] = 7'b1111000; pat_tab[8] = 7'b0000000;
    pat_tab[9] = 7'b0010000;
    vecs[0] = '{{pat_tab[4], pat_tab[3], pat_tab[2], pat_tab[1]}, 16'h4321, 1'b0};
    vecs[1] = '{{pat_tab[7], pat_tab[6], 7'b1010101, pat_tab[5]}, 16'h76F5, 1'b1};
    vecs[2] = '{{pat_tab[1], pat_tab[0], pat_tab[9], pat_tab[8]}, 16'h1098, 1'b0};
    vecs[3] = '{{pat_tab[9], 7'h7F, pat_tab[3], pat_tab[2]}, 16'h9A32, 1'b0};
    fv_cnt = 0;
    ae_cnt = 0;
    last_digits = 16'h0;
    last_fe = 1'b0;

    #2 apply_reset();

    // Clean, faulty-tens and blank-hundreds frames, each followed by an idle flush.
    for (int v = 0; v < 4; v++) begin
      fv_cnt = 0;
      scan(vecs[v].pats, 8);
      hold(7'h7F, 4'hF, 3);
      check("frames_per_scan", fv_cnt, 1);
      check("frame_digits", last_digits, vecs[v].exp_digits);
      check("frame_err", last_fe, vecs[v].exp_fe);
      check("stale_clear", stale, 0);
    end

    // Dwell one sample short of capture: no frames, stale rises, a clean scan recovers.
    fv_cnt = 0;
    for (int n = 0; n < 95; n++) scan(vecs[0].pats, Stable - 1);
    check("short_dwell_frames", fv_cnt, 0);
    check("stale_set", stale, 1);
    scan(vecs[2].pats, 8);
    hold(7'h7F, 4'hF, 3);
    check("stale_recover_frames", fv_cnt, 1);
    check("stale_recovered", stale, 0);

    // Two anodes low mid-scan: one anode_err pulse, frame still completes.
    fv_cnt = 0;
    ae_cnt = 0;
    hold(pat_tab[6], 4'b1110, 8);
    hold(pat_tab[7], 4'b1101, 8);
    hold(pat_tab[3], 4'b1100, 10);
    hold(pat_tab[8], 4'b1011, 8);
    hold(pat_tab[9], 4'b0111, 8);
    hold(7'h7F, 4'hF, 3);
    check("anode_err_pulses", ae_cnt, 1);
    check("bad_scan_frames", fv_cnt, 1);
    check("bad_scan_digits", last_digits, 16'h9876);

    // Reset mid-SETTLE with three digits captured; the partial mask must not survive.
    hold(pat_tab[5], 4'b1110, 8);
    hold(pat_tab[5], 4'b1101, 8);
    hold(pat_tab[5], 4'b1011, 8);
    hold(pat_tab[1], 4'b0111, 4);
    apply_reset();
    fv_cnt = 0;
    hold(pat_tab[7], 4'b0111, 8);
    hold(7'h7F, 4'hF, 4);
    check("post_reset_no_frame", fv_cnt, 0);
    scan({pat_tab[7], pat_tab[2], pat_tab[0], pat_tab[5]}, 8);
    hold(7'h7F, 4'hF, 3);
    check("post_reset_frames", fv_cnt, 1);
    check("post_reset_digits", last_digits, 16'h7205);

    // Random bus traffic, checked every cycle by the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] d;
      logic [6:0] s;
      int r;
      r = $urandom_range(99);
      if (r < 70) begin
        d = ~(4'b0001 << $urandom_range(3));
      end else if (r < 85) begin
        d = 4'hF;
      end else begin
        do d = 4'($urandom); while (d == 4'hF || $countones(~d) == 1);
      end
      r = $urandom_range(99);
      if (r < 60) s = pat_tab[$urandom_range(9)];
      else if (r < 75) s = 7'h7F;
      else s = 7'($urandom);
      hold(s, d, $urandom_range(9, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
